bp_be_vcache_evict_queue: RTL and testbench
===========================================

Name: bp_be_vcache_evict_queue

Overview:
- Producer side of the victim cache: accepts lines evicted by the dcache and feeds them to the victim cache's insert port.
- Drives the insert port as a one-cycle pulse on data_valid plus tag_valid.
- Buffers evictions in a small FIFO; dirty lines are also written back to memory over a valid/ready channel.
- Provides a probe port so a dcache miss can hit on a line still waiting in the queue.

Parameters:
- block_width_p, 512, line width in bits.
- vcache_tag_width_p, 30, line tag width; matches the victim cache tag_i width.
- els_p, 4, queue entries; power of two, minimum 2.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- evict_v_i  in  1  eviction valid
- evict_ready_o  out  1  queue can accept
- evict_tag_i  in  vcache_tag_width_p  evicted line tag
- evict_data_i  in  block_width_p  evicted line data
- evict_dirty_i  in  1  line needs memory writeback
- lookup_busy_i  in  1  dcache is using the vcache tag port this cycle; suppresses insert
- vcache_data_valid_o  out  1  insert pulse, data
- vcache_tag_valid_o  out  1  insert pulse, tag
- vcache_tag_o  out  vcache_tag_width_p  insert tag
- vcache_data_o  out  block_width_p  insert data
- wb_v_o  out  1  writeback valid
- wb_ready_i  in  1  memory accepts writeback
- wb_tag_o  out  vcache_tag_width_p  writeback tag
- wb_data_o  out  block_width_p  writeback data
- probe_v_i  in  1  probe request
- probe_tag_i  in  vcache_tag_width_p  probe tag
- probe_hit_o  out  1  registered probe hit
- probe_data_o  out  block_width_p  registered probe data
- empty_o  out  1  queue empty and FSM idle

Behaviour:
- Reset: all outputs 0 except evict_ready_o=1 and empty_o=1; queue flushed; FSM to S_IDLE. Reset mid-writeback abandons the transfer; wb_v_o is 0 the cycle after reset.
- Push:
  - Occurs when evict_v_i && evict_ready_o.
  - evict_ready_o = (count != els_p), combinational from count only, with no same-cycle pop bypass. When full, ready stays low even if a pop occurs.
  - Push and pop in the same cycle leave count unchanged.
- FSM on the head entry:
  - S_IDLE: go to S_INSERT when count != 0 (one cycle after the first push).
  - S_INSERT:
    - If lookup_busy_i, wait.
    - Otherwise assert vcache_data_valid_o and vcache_tag_valid_o for exactly one cycle with the head tag and data.
    - Next state: S_WB if head is dirty; otherwise pop the head and go to S_INSERT if count after pop != 0, else S_IDLE.
  - S_WB:
    - Hold wb_v_o=1 with stable head tag and data until wb_ready_i is high; pop on that cycle.
    - Next state: S_INSERT or S_IDLE by the same rule as S_INSERT.
- Minimum occupancy per entry: clean line 1 cycle in S_INSERT; dirty line 1 cycle in S_INSERT plus at least 1 cycle in S_WB.
- Outputs when inactive: insert outputs and wb outputs are 0 outside their states.
- Probe:
  - Compares probe_tag_i against all valid entries using pre-pop and pre-push state; an entry being popped this cycle still hits, and an entry being pushed this cycle does not.
  - The youngest matching entry wins.
  - probe_hit_o and probe_data_o are registered: valid the cycle after probe_v_i, and 0 when probe_v_i was low.
- Pointers: head and tail wrap modulo els_p; count width is $clog2(els_p)+1.

Optional Feature:
- Macro: BP_VCACHE_EVICT_COALESCE_EN.
- Defined:
  - A push whose tag matches a queued non-head entry overwrites that entry's data in place, ORs its dirty bit, and does not allocate.
  - Coalescing is allowed even when the queue is full; in that case evict_ready_o = full ? coalesce_match : 1.
  - A match on the head entry only allocates normally.
- Undefined: every push allocates, and duplicate tags may coexist in the queue.

Decomposition:
- Package bp_be_vcache_pkg holds:
  - the entry struct typedef (tag, data, dirty), parameterised via macro;
  - the FSM state enum {S_IDLE, S_INSERT, S_WB}.
- Sub-module bp_be_vcache_evict_fifo holds storage, head/tail/count and the probe CAM search.
- The top level holds the FSM, the insert/wb output muxing and the probe output register.

Test Plan:
- Clean single eviction: push tag 0x10, clean, with lookup_busy_i=0 -> insert pulse 2 cycles after push with vcache_tag_o=0x10; wb_v_o never asserts; empty_o=1 afterwards.
- Dirty eviction with backpressure: push tag 0x22, dirty, with wb_ready_i low for 5 cycles -> one insert pulse, then wb_v_o high for 6 cycles with stable data; pop on the ready cycle.
- Full queue: push 4 entries while lookup_busy_i=1 -> evict_ready_o=0 after the 4th; no insert pulses issued; release busy -> inserts in FIFO order 0,1,2,3.
- Probe: queue tags 0x5 (data A) and 0x5 (data B, younger); probe 0x5 -> next cycle probe_hit_o=1 with data B. Probe 0x6 -> probe_hit_o=0.
- Reset mid-S_WB: assert reset_i while wb_v_o=1 -> next cycle wb_v_o=0, empty_o=1, evict_ready_o=1.
- With BP_VCACHE_EVICT_COALESCE_EN: push 0x1, 0x2, then 0x2 dirty with new data -> count stays 2; the single 0x2 entry is written back with the new data.

Source files
------------

// File: rtl/bp_be_vcache_pkg.sv
// Shared types for the victim-cache eviction queue: FSM states and the queued-line entry.
// The entry struct is declared by macro so each module can size it from its own parameters.
`ifndef BP_BE_VCACHE_PKG_SV
`define BP_BE_VCACHE_PKG_SV

`define BP_BE_VCACHE_DECLARE_ENTRY_S(name_mp, tag_width_mp, data_width_mp) \
    typedef struct packed { \
        logic [tag_width_mp-1:0]  tag; \
        logic [data_width_mp-1:0] data; \
        logic                     dirty; \
    } name_mp

package bp_be_vcache_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_INSERT,
        S_WB
    } bp_be_vcache_state_e;

    `BP_BE_VCACHE_DECLARE_ENTRY_S(bp_be_vcache_entry_s, 30, 512);

endpackage

`endif

// File: rtl/bp_be_vcache_evict_fifo.sv
// Eviction storage: circular buffer with head/tail/count and a youngest-wins probe CAM (coalescing under BP_VCACHE_EVICT_COALESCE_EN).
// Latency: push visible in count next cycle; head and probe results are combinational from current state.
// Backpressure: ready_o low when full (or, with coalescing, when full and the tag has no non-head match).
module bp_be_vcache_evict_fifo
    import bp_be_vcache_pkg::*;
#(
    parameter int tag_width_p  = 30,
    parameter int data_width_p = 512,
    parameter int els_p        = 4,
    localparam int PW          = $clog2(els_p),
    localparam int CW          = PW + 1
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    push_v_i,
    input  logic [tag_width_p-1:0]  push_tag_i,
    input  logic [data_width_p-1:0] push_data_i,
    input  logic                    push_dirty_i,
    output logic                    ready_o,
    output logic                    alloc_o,
    input  logic                    pop_i,
    output logic [tag_width_p-1:0]  head_tag_o,
    output logic [data_width_p-1:0] head_data_o,
    output logic                    head_dirty_o,
    output logic [CW-1:0]           count_o,
    input  logic [tag_width_p-1:0]  probe_tag_i,
    output logic                    probe_hit_o,
    output logic [data_width_p-1:0] probe_data_o
);

    `BP_BE_VCACHE_DECLARE_ENTRY_S(entry_s, tag_width_p, data_width_p);

    entry_s          mem_q [els_p];
    entry_s          mem_d [els_p];
    logic [PW-1:0]   head_q, head_d, tail_q, tail_d, probe_idx;
    logic [CW-1:0]   count_q, count_d;
    logic            full, push_fire, co_match;

    assign full      = (count_q == CW'(els_p));
    assign push_fire = push_v_i & ready_o;
    assign alloc_o   = push_fire & ~co_match;

`ifdef BP_VCACHE_EVICT_COALESCE_EN
    logic [PW-1:0] co_idx, co_scan;

    // The head is skipped: it may already be in flight to the vcache or memory.
    always_comb begin
        co_match = 1'b0;
        co_idx   = '0;
        co_scan  = '0;
        for (int i = 1; i < els_p; i++) begin
            co_scan = head_q + PW'(i);
            if ((CW'(i) < count_q) && (mem_q[co_scan].tag == push_tag_i)) begin
                co_match = 1'b1;
                co_idx   = co_scan;
            end
        end
    end

    assign ready_o = full ? co_match : 1'b1;
`else
    assign co_match = 1'b0;
    assign ready_o  = ~full;
`endif

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (alloc_o) begin
            mem_d[tail_q] = '{tag: push_tag_i, data: push_data_i, dirty: push_dirty_i};
            tail_d        = tail_q + PW'(1);
        end
`ifdef BP_VCACHE_EVICT_COALESCE_EN
        if (push_fire && co_match) begin
            mem_d[co_idx].data  = push_data_i;
            mem_d[co_idx].dirty = mem_q[co_idx].dirty | push_dirty_i;
        end
`endif
        if (pop_i) begin
            head_d = head_q + PW'(1);
        end
        count_d = count_q + CW'(alloc_o) - CW'(pop_i);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    // Scan oldest to youngest so the last match (youngest) wins.
    always_comb begin
        probe_hit_o  = 1'b0;
        probe_data_o = '0;
        probe_idx    = '0;
        for (int i = 0; i < els_p; i++) begin
            probe_idx = head_q + PW'(i);
            if ((CW'(i) < count_q) && (mem_q[probe_idx].tag == probe_tag_i)) begin
                probe_hit_o  = 1'b1;
                probe_data_o = mem_q[probe_idx].data;
            end
        end
    end

    assign head_tag_o   = mem_q[head_q].tag;
    assign head_data_o  = mem_q[head_q].data;
    assign head_dirty_o = mem_q[head_q].dirty;
    assign count_o      = count_q;

endmodule

// File: rtl/bp_be_vcache_evict_queue.sv
// Victim-cache producer: queues dcache evictions, pulses the vcache insert port, writes dirty lines back (BP_VCACHE_EVICT_COALESCE_EN merges repeats).
// Latency: first insert pulse two cycles after a push into an empty queue; probe result registered, one cycle.
// Backpressure: evict_ready_o drops when full; insert waits on lookup_busy_i, writeback holds until wb_ready_i.
module bp_be_vcache_evict_queue
    import bp_be_vcache_pkg::*;
#(
    parameter int block_width_p      = 512,
    parameter int vcache_tag_width_p = 30,
    parameter int els_p              = 4
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          evict_v_i,
    output logic                          evict_ready_o,
    input  logic [vcache_tag_width_p-1:0] evict_tag_i,
    input  logic [block_width_p-1:0]      evict_data_i,
    input  logic                          evict_dirty_i,
    input  logic                          lookup_busy_i,
    output logic                          vcache_data_valid_o,
    output logic                          vcache_tag_valid_o,
    output logic [vcache_tag_width_p-1:0] vcache_tag_o,
    output logic [block_width_p-1:0]      vcache_data_o,
    output logic                          wb_v_o,
    input  logic                          wb_ready_i,
    output logic [vcache_tag_width_p-1:0] wb_tag_o,
    output logic [block_width_p-1:0]      wb_data_o,
    input  logic                          probe_v_i,
    input  logic [vcache_tag_width_p-1:0] probe_tag_i,
    output logic                          probe_hit_o,
    output logic [block_width_p-1:0]      probe_data_o,
    output logic                          empty_o
);

    localparam int CW = $clog2(els_p) + 1;

    bp_be_vcache_state_e             state_q, state_d;
    logic                            pop, ins, wb_v, alloc, more;
    logic [vcache_tag_width_p-1:0]   head_tag;
    logic [block_width_p-1:0]        head_data, cam_data;
    logic                            head_dirty, cam_hit;
    logic [CW-1:0]                   count;
    logic                            probe_hit_q, probe_hit_d;
    logic [block_width_p-1:0]        probe_data_q, probe_data_d;

    bp_be_vcache_evict_fifo #(
        .tag_width_p (vcache_tag_width_p),
        .data_width_p(block_width_p),
        .els_p       (els_p)
    ) fifo (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .push_v_i    (evict_v_i),
        .push_tag_i  (evict_tag_i),
        .push_data_i (evict_data_i),
        .push_dirty_i(evict_dirty_i),
        .ready_o     (evict_ready_o),
        .alloc_o     (alloc),
        .pop_i       (pop),
        .head_tag_o  (head_tag),
        .head_data_o (head_data),
        .head_dirty_o(head_dirty),
        .count_o     (count),
        .probe_tag_i (probe_tag_i),
        .probe_hit_o (cam_hit),
        .probe_data_o(cam_data)
    );

    // Entries remaining once the head leaves, counting a same-cycle allocation.
    assign more = (count > CW'(1)) | alloc;

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        ins     = 1'b0;
        wb_v    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (count != '0) state_d = S_INSERT;
            end
            S_INSERT: begin
                if (!lookup_busy_i) begin
                    ins = 1'b1;
                    if (head_dirty) begin
                        state_d = S_WB;
                    end else begin
                        pop     = 1'b1;
                        state_d = more ? S_INSERT : S_IDLE;
                    end
                end
            end
            S_WB: begin
                wb_v = 1'b1;
                if (wb_ready_i) begin
                    pop     = 1'b1;
                    state_d = more ? S_INSERT : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign vcache_data_valid_o = ins;
    assign vcache_tag_valid_o  = ins;
    assign vcache_tag_o        = ins ? head_tag  : '0;
    assign vcache_data_o       = ins ? head_data : '0;
    assign wb_v_o              = wb_v;
    assign wb_tag_o            = wb_v ? head_tag  : '0;
    assign wb_data_o           = wb_v ? head_data : '0;
    assign empty_o             = (count == '0) && (state_q == S_IDLE);

    always_comb begin
        probe_hit_d  = probe_v_i & cam_hit;
        probe_data_d = (probe_v_i & cam_hit) ? cam_data : '0;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            probe_hit_q  <= 1'b0;
            probe_data_q <= '0;
        end else begin
            state_q      <= state_d;
            probe_hit_q  <= probe_hit_d;
            probe_data_q <= probe_data_d;
        end
    end

    assign probe_hit_o  = probe_hit_q;
    assign probe_data_o = probe_data_q;

endmodule

// File: tb/tb_bp_be_vcache_evict_queue.sv
// Directed bench for the eviction queue: queue-level reference model checked every cycle plus literal pins.
module tb_bp_be_vcache_evict_queue;

    localparam int BW  = 512;
    localparam int TW  = 30;
    localparam int ELS = 4;

    logic          clk = 1'b0;
    logic          reset_i, evict_v_i, evict_dirty_i, lookup_busy_i, wb_ready_i, probe_v_i;
    logic [TW-1:0] evict_tag_i, probe_tag_i;
    logic [BW-1:0] evict_data_i;
    logic          evict_ready_o, vcache_data_valid_o, vcache_tag_valid_o, wb_v_o, probe_hit_o, empty_o;
    logic [TW-1:0] vcache_tag_o, wb_tag_o;
    logic [BW-1:0] vcache_data_o, wb_data_o, probe_data_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bp_be_vcache_evict_queue #(
        .block_width_p     (BW),
        .vcache_tag_width_p(TW),
        .els_p             (ELS)
    ) dut (
        .clk_i              (clk),
        .reset_i            (reset_i),
        .evict_v_i          (evict_v_i),
        .evict_ready_o      (evict_ready_o),
        .evict_tag_i        (evict_tag_i),
        .evict_data_i       (evict_data_i),
        .evict_dirty_i      (evict_dirty_i),
        .lookup_busy_i      (lookup_busy_i),
        .vcache_data_valid_o(vcache_data_valid_o),
        .vcache_tag_valid_o (vcache_tag_valid_o),
        .vcache_tag_o       (vcache_tag_o),
        .vcache_data_o      (vcache_data_o),
        .wb_v_o             (wb_v_o),
        .wb_ready_i         (wb_ready_i),
        .wb_tag_o           (wb_tag_o),
        .wb_data_o          (wb_data_o),
        .probe_v_i          (probe_v_i),
        .probe_tag_i        (probe_tag_i),
        .probe_hit_o        (probe_hit_o),
        .probe_data_o       (probe_data_o),
        .empty_o            (empty_o)
    );

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [BW-1:0] mk(input logic [31:0] s);
        return {16{s}};
    endfunction

    // Reference model: the queue as a list of lines, "engaged" meaning the engine
    // has noticed a non-empty queue, "done" meaning the head is inserted and awaits writeback.
    typedef struct {
        logic [TW-1:0] tag;
        logic [BW-1:0] data;
        logic          dirty;
    } ent_t;

    ent_t          mq[$];
    ent_t          tmp;
    bit            m_valid = 0, m_eng = 0, m_done = 0, m_phit = 0;
    logic [BW-1:0] m_pdata = '0;
    int            n, co_idx;
    bit            co_hit, e_ready, e_ins, e_wb, p_hit, do_pop, pushed, h_dirty;
    logic [TW-1:0] h_tag;
    logic [BW-1:0] h_data, p_data;

    always @(negedge clk) begin
        if (m_valid) begin
            n      = mq.size();
            co_hit = 0;
            co_idx = 0;
`ifdef BP_VCACHE_EVICT_COALESCE_EN
            for (int i = 1; i < n; i++)
                if (mq[i].tag == evict_tag_i) begin
                    co_hit = 1;
                    co_idx = i;
                end
            e_ready = (n == ELS) ? co_hit : 1'b1;
`else
            e_ready = (n != ELS);
`endif
            h_tag   = (n != 0) ? mq[0].tag   : '0;
            h_data  = (n != 0) ? mq[0].data  : '0;
            h_dirty = (n != 0) ? mq[0].dirty : 1'b0;
            e_ins   = m_eng && !m_done && !lookup_busy_i;
            e_wb    = m_eng && m_done;

            chk("evict_ready", BW'(evict_ready_o), BW'(e_ready));
            chk("empty", BW'(empty_o), BW'((n == 0) && !m_eng));
            chk("ins_data_valid", BW'(vcache_data_valid_o), BW'(e_ins));
            chk("ins_tag_valid", BW'(vcache_tag_valid_o), BW'(e_ins));
            chk("ins_tag", BW'(vcache_tag_o), e_ins ? BW'(h_tag) : '0);
            chk("ins_data", vcache_data_o, e_ins ? h_data : '0);
            chk("wb_v", BW'(wb_v_o), BW'(e_wb));
            chk("wb_tag", BW'(wb_tag_o), e_wb ? BW'(h_tag) : '0);
            chk("wb_data", wb_data_o, e_wb ? h_data : '0);
            chk("probe_hit", BW'(probe_hit_o), BW'(m_phit));
            chk("probe_data", probe_data_o, m_pdata);

            p_hit  = 0;
            p_data = '0;
            for (int i = 0; i < n; i++)
                if (mq[i].tag == probe_tag_i) begin
                    p_hit  = 1;
                    p_data = mq[i].data;
                end
            if (!probe_v_i) begin
                p_hit  = 0;
                p_data = '0;
            end
            do_pop = (e_ins && !h_dirty) || (e_wb && wb_ready_i);
            pushed = evict_v_i && e_ready;
            if (pushed && co_hit) begin
                tmp        = mq[co_idx];
                tmp.data   = evict_data_i;
                tmp.dirty  = tmp.dirty | evict_dirty_i;
                mq[co_idx] = tmp;
            end
            if (do_pop) void'(mq.pop_front());
            if (pushed && !co_hit) begin
                tmp.tag   = evict_tag_i;
                tmp.data  = evict_data_i;
                tmp.dirty = evict_dirty_i;
                mq.push_back(tmp);
            end
            m_done  = do_pop ? 1'b0 : ((e_ins && h_dirty) ? 1'b1 : m_done);
            m_eng   = m_eng ? (mq.size() != 0) : (n != 0);
            m_phit  = p_hit;
            m_pdata = p_data;
        end
        if (reset_i) begin
            mq.delete();
            m_eng   = 0;
            m_done  = 0;
            m_phit  = 0;
            m_pdata = '0;
            m_valid = 1;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [TW-1:0] tag, input logic [BW-1:0] data, input logic dirty);
        evict_v_i     = 1'b1;
        evict_tag_i   = tag;
        evict_data_i  = data;
        evict_dirty_i = dirty;
        cyc();
        evict_v_i     = 1'b0;
    endtask

    initial begin
        reset_i = 1'b1; evict_v_i = 1'b0; evict_dirty_i = 1'b0; lookup_busy_i = 1'b0;
        wb_ready_i = 1'b0; probe_v_i = 1'b0; evict_tag_i = '0; probe_tag_i = '0; evict_data_i = '0;
        cyc();
        cyc();
        reset_i = 1'b0;
        #2;
        chk("rst_ready", BW'(evict_ready_o), BW'(1));
        chk("rst_empty", BW'(empty_o), BW'(1));
        chk("rst_wb_v", BW'(wb_v_o), BW'(0));
        chk("rst_ins", BW'(vcache_data_valid_o), BW'(0));
        chk("rst_probe_hit", BW'(probe_hit_o), BW'(0));

        // Clean single eviction: pulse two cycles after the push.
        push(30'h10, mk(32'h1111_0010), 1'b0);
        #2 chk("clean_no_pulse_p1", BW'(vcache_data_valid_o), BW'(0));
        cyc();
        #2 chk("clean_pulse_p2", BW'(vcache_tag_valid_o), BW'(1));
        chk("clean_pulse_tag", BW'(vcache_tag_o), BW'(30'h10));
        chk("clean_pulse_data", vcache_data_o, mk(32'h1111_0010));
        cyc();
        #2 chk("clean_empty_after", BW'(empty_o), BW'(1));

        // Dirty eviction, writeback stalled for five cycles.
        push(30'h22, mk(32'h2222_0022), 1'b1);
        cyc();
        #2 chk("dirty_pulse", BW'(vcache_data_valid_o), BW'(1));
        for (int k = 0; k < 5; k++) begin
            cyc();
            #2 chk("dirty_wb_hold", BW'(wb_v_o), BW'(1));
            chk("dirty_wb_data", wb_data_o, mk(32'h2222_0022));
        end
        cyc();
        wb_ready_i = 1'b1;
        #2 chk("dirty_wb_sixth", BW'(wb_v_o), BW'(1));
        chk("dirty_wb_tag", BW'(wb_tag_o), BW'(30'h22));
        cyc();
        wb_ready_i = 1'b0;
        #2 chk("dirty_wb_done", BW'(wb_v_o), BW'(0));
        chk("dirty_empty", BW'(empty_o), BW'(1));

        // Full queue while the tag port is busy, then drain in order.
        lookup_busy_i = 1'b1;
        for (int k = 0; k < 4; k++) push(30'h30 + TW'(k), mk(32'h3300_0000 + k), 1'b0);
        #2 chk("full_ready_low", BW'(evict_ready_o), BW'(0));
        chk("full_no_pulse", BW'(vcache_data_valid_o), BW'(0));
        push(30'h34, mk(32'h3300_0004), 1'b0);
        lookup_busy_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #2 chk("full_drain_tag", BW'(vcache_tag_o), BW'(30'h30 + TW'(k)));
            cyc();
        end
        #2 chk("full_drain_done", BW'(vcache_data_valid_o), BW'(0));
        chk("full_drained_empty", BW'(empty_o), BW'(1));

        // Probe: youngest duplicate wins; a line pushed in the probe cycle does not hit.
        lookup_busy_i = 1'b1;
        push(30'h5, mk(32'hAAAA_0005), 1'b0);
        push(30'h5, mk(32'hBBBB_0005), 1'b0);
        probe_v_i   = 1'b1;
        probe_tag_i = 30'h7;
        push(30'h7, mk(32'hCCCC_0007), 1'b0);
        #2 chk("probe_same_cycle_push", BW'(probe_hit_o), BW'(0));
        probe_tag_i = 30'h5;
        cyc();
        #2 chk("probe_dup_hit", BW'(probe_hit_o), BW'(1));
        chk("probe_dup_data", probe_data_o, mk(32'hBBBB_0005));
        probe_tag_i = 30'h6;
        cyc();
        #2 chk("probe_miss", BW'(probe_hit_o), BW'(0));
        probe_tag_i = 30'h7;
        cyc();
        #2 chk("probe_hit_c", probe_data_o, mk(32'hCCCC_0007));
        probe_v_i     = 1'b0;
        lookup_busy_i = 1'b0;
        for (int k = 0; k < 4; k++) cyc();
        #2 chk("probe_drained", BW'(empty_o), BW'(1));

`ifdef BP_VCACHE_EVICT_COALESCE_EN
        lookup_busy_i = 1'b1;
        push(30'h1, mk(32'hD1D1_0001), 1'b0);
        push(30'h2, mk(32'hD2D2_0002), 1'b0);
        push(30'h2, mk(32'hEEEE_0002), 1'b1);
        lookup_busy_i = 1'b0;
        #2 chk("co_first_tag", BW'(vcache_tag_o), BW'(30'h1));
        cyc();
        #2 chk("co_second_tag", BW'(vcache_tag_o), BW'(30'h2));
        chk("co_second_data", vcache_data_o, mk(32'hEEEE_0002));
        cyc();
        wb_ready_i = 1'b1;
        #2 chk("co_wb_v", BW'(wb_v_o), BW'(1));
        chk("co_wb_data", wb_data_o, mk(32'hEEEE_0002));
        cyc();
        wb_ready_i = 1'b0;
        #2 chk("co_empty", BW'(empty_o), BW'(1));
        chk("co_no_third", BW'(vcache_data_valid_o), BW'(0));
`endif

        // Reset in the middle of a writeback abandons it.
        push(30'h40, mk(32'h4444_0040), 1'b1);
        cyc();
        cyc();
        #2 chk("rst_wb_active", BW'(wb_v_o), BW'(1));
        reset_i = 1'b1;
        cyc();
        reset_i = 1'b0;
        #2 chk("rst_wb_dropped", BW'(wb_v_o), BW'(0));
        chk("rst_wb_empty", BW'(empty_o), BW'(1));
        chk("rst_wb_ready", BW'(evict_ready_o), BW'(1));

        for (int k = 0; k < 3; k++) cyc();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
